norm2_lrn_sqsum: RTL and testbench

Cross-channel sum-of-squares window for the norm2 LRN layer. It accepts one signed activation per channel, in channel order, for each pixel. For every channel c it emits S[c] = sum of x[k]^2 for k in [c-HALF, c+HALF], with out-of-range k contributing 0. It sits directly upstream of the alpha-scaling multiply (10-bit signed coefficient × 36-bit signed sum) and drives its 36-bit operand.

---
 rtl/norm2_lrn_sqsum_if.sv | 24 ++
 rtl/norm2_lrn_sqsum.sv | 121 ++++++++++++
 tb/tb_norm2_lrn_sqsum.sv | 235 +++++++++++++++++++++++
 3 files changed

// File: rtl/norm2_lrn_sqsum_if.sv
// Stream bundle for the LRN sum-of-squares stage: activations in, window sums out.
// The slave modport is the block's view; master is the producer/consumer side.
interface norm2_lrn_sqsum_if #(
   parameter int DIN_WIDTH  = 16,
   parameter int DOUT_WIDTH = 36
);
   logic signed [DIN_WIDTH-1:0] in_data;
   logic                        in_valid;
   logic                        in_ready;
   logic [DOUT_WIDTH-1:0]       out_data;
   logic                        out_valid;
   logic                        out_ready;
   logic                        out_last;

   modport slave (
      input  in_data, in_valid, out_ready,
      output in_ready, out_data, out_valid, out_last
   );

   modport master (
      output in_data, in_valid, out_ready,
      input  in_ready, out_data, out_valid, out_last
   );
endinterface

// File: rtl/norm2_lrn_sqsum.sv
// Cross-channel sum of squares over a LOCAL_SIZE window, one channel per cycle,
// with a HALF-cycle flush at the end of each pixel to emit the trailing channels.
module norm2_lrn_sqsum #(
   parameter int CHANNELS   = 256,
   parameter int LOCAL_SIZE = 5,
   parameter int DIN_WIDTH  = 16,
   parameter int DOUT_WIDTH = 36
) (
   input  logic             ap_clk,
   input  logic             ap_rst,
   norm2_lrn_sqsum_if.slave s
);
   localparam int HALF = (LOCAL_SIZE - 1) / 2;
   localparam int CW   = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
   localparam int FW   = (HALF > 1) ? $clog2(HALF) : 1;

   typedef enum logic {RUN, FLUSH} state_t;

   state_t                 state_q, state_d;
   logic [CW-1:0]          chan_q, chan_d;
   logic [FW-1:0]          flush_q, flush_d;
   logic [DOUT_WIDTH-1:0]  sum_q, sum_d;
   logic [DOUT_WIDTH-1:0]  win_q [LOCAL_SIZE];
   logic [DOUT_WIDTH-1:0]  win_d [LOCAL_SIZE];
   logic [DOUT_WIDTH-1:0]  win_shift [LOCAL_SIZE];
   logic [DOUT_WIDTH-1:0]  out_data_q, out_data_d;
   logic                   out_valid_q, out_valid_d;
   logic                   out_last_q, out_last_d;

   logic signed [2*DIN_WIDTH-1:0] prod;
   logic [DOUT_WIDTH-1:0]  sq;
   logic [DOUT_WIDTH-1:0]  shift_in;
   logic                   can_load;
   logic                   in_ready;
   logic                   accept;
   logic                   flush_step;

   assign prod       = s.in_data * s.in_data;
   assign sq         = DOUT_WIDTH'($unsigned(prod));
   assign can_load   = !out_valid_q || s.out_ready;
   assign in_ready   = (state_q == RUN) && can_load;
   assign accept     = in_ready && s.in_valid;
   assign flush_step = (state_q == FLUSH) && can_load;
   assign shift_in   = (state_q == RUN) ? sq : '0;

   // win_q[0] holds the newest square; the oldest one drops out of the sum.
   assign win_shift[0] = shift_in;
   genvar gi;
   generate
      for (gi = 1; gi < LOCAL_SIZE; gi++) begin : g_shift
         assign win_shift[gi] = win_q[gi-1];
      end
   endgenerate

   always_comb begin
      state_d     = state_q;
      chan_d      = chan_q;
      flush_d     = flush_q;
      sum_d       = sum_q;
      win_d       = win_q;
      out_data_d  = out_data_q;
      out_valid_d = out_valid_q && !s.out_ready;
      out_last_d  = out_last_q;
      if (accept) begin
         sum_d  = sum_q + sq - win_q[LOCAL_SIZE-1];
         win_d  = win_shift;
         chan_d = chan_q + 1'b1;
         if (chan_q >= CW'(HALF)) begin
            out_data_d  = sum_d;
            out_valid_d = 1'b1;
            out_last_d  = 1'b0;
         end
         if (chan_q == CW'(CHANNELS - 1)) begin
            state_d = FLUSH;
            flush_d = '0;
            chan_d  = '0;
         end
      end else if (flush_step) begin
         sum_d       = sum_q - win_q[LOCAL_SIZE-1];
         win_d       = win_shift;
         out_data_d  = sum_d;
         out_valid_d = 1'b1;
         out_last_d  = (flush_q == FW'(HALF - 1));
         if (flush_q == FW'(HALF - 1)) begin
            state_d = RUN;
            chan_d  = '0;
            sum_d   = '0;
            win_d   = '{default: '0};
         end else begin
            flush_d = flush_q + 1'b1;
         end
      end
   end

   always_ff @(posedge ap_clk) begin
      if (ap_rst) begin
         state_q     <= RUN;
         chan_q      <= '0;
         flush_q     <= '0;
         sum_q       <= '0;
         win_q       <= '{default: '0};
         out_data_q  <= '0;
         out_valid_q <= 1'b0;
         out_last_q  <= 1'b0;
      end else begin
         state_q     <= state_d;
         chan_q      <= chan_d;
         flush_q     <= flush_d;
         sum_q       <= sum_d;
         win_q       <= win_d;
         out_data_q  <= out_data_d;
         out_valid_q <= out_valid_d;
         out_last_q  <= out_last_d;
      end
   end

   assign s.in_ready  = in_ready;
   assign s.out_data  = out_data_q;
   assign s.out_valid = out_valid_q;
   assign s.out_last  = out_last_q;
endmodule

// File: tb/tb_norm2_lrn_sqsum.sv
// Scoreboard bench for norm2_lrn_sqsum: a windowed sum-of-squares model feeds
// an expectation queue that a free-running monitor drains on every output pop.
module tb_norm2_lrn_sqsum;
   localparam int CH   = 8;
   localparam int LS   = 5;
   localparam int HALF = (LS - 1) / 2;
   localparam int DW   = 16;
   localparam int OW   = 36;

   typedef logic signed [DW-1:0] pix_t [CH];
   typedef struct {
      logic [OW-1:0] d;
      logic          last;
   } exp_t;

   logic ap_clk;
   logic ap_rst;
   norm2_lrn_sqsum_if #(.DIN_WIDTH(DW), .DOUT_WIDTH(OW)) bus();

   norm2_lrn_sqsum #(
      .CHANNELS(CH), .LOCAL_SIZE(LS), .DIN_WIDTH(DW), .DOUT_WIDTH(OW)
   ) dut (
      .ap_clk(ap_clk),
      .ap_rst(ap_rst),
      .s     (bus)
   );

   exp_t exp_q[$];
   int   total = 0;
   int   bad   = 0;
   bit   rdy_mode   = 0;
   bit   ignore_out = 0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
      total++;
      if (act !== req) begin
         bad++;
         $display("FAIL %s: got %0d expected %0d", name, act, req);
      end
   endtask

   // S[c] straight from the definition: squares of x[c-HALF..c+HALF], out-of-range = 0.
   function automatic void model(input pix_t x);
      for (int c = 0; c < CH; c++) begin
         longint sum = 0;
         exp_t   e;
         for (int k = c - HALF; k <= c + HALF; k++)
            if (k >= 0 && k < CH) sum += longint'(x[k]) * longint'(x[k]);
         e.d    = OW'(sum);
         e.last = (c == CH - 1);
         exp_q.push_back(e);
      end
   endfunction

   initial begin
      ap_clk = 0;
      forever #5 ap_clk = ~ap_clk;
   end

   initial begin
      bus.out_ready = 1'b1;
      forever begin
         @(posedge ap_clk);
         #1;
         bus.out_ready = rdy_mode ? 1'($urandom_range(0, 1)) : 1'b1;
      end
   end

   initial begin : monitor
      bit            stall_prev = 0;
      logic [OW-1:0] held_d = '0;
      logic          held_l = 0;
      exp_t          e;
      forever begin
         @(negedge ap_clk);
         if (ap_rst) begin
            stall_prev = 0;
            continue;
         end
         if (stall_prev) begin
            check("stall_valid", bus.out_valid, 1);
            check("stall_data", bus.out_data, held_d);
            check("stall_last", bus.out_last, held_l);
         end
         if (bus.out_valid && !bus.out_ready)
            check("in_ready_stall", bus.in_ready, 0);
         if (bus.out_valid && bus.out_ready && !ignore_out) begin
            if (exp_q.size() == 0) begin
               total++;
               bad++;
               $display("FAIL unexpected_out: got %0d expected no word", bus.out_data);
            end else begin
               e = exp_q.pop_front();
               check("out_data", bus.out_data, e.d);
               check("out_last", bus.out_last, e.last);
               check("out_msb", bus.out_data[OW-1], 0);
            end
         end
         stall_prev = bus.out_valid && !bus.out_ready;
         held_d     = bus.out_data;
         held_l     = bus.out_last;
      end
   end

   task automatic send_pixel(input pix_t x, input int n, input bit gaps, input bit chk_lat,
                             output int gap0);
      gap0 = 0;
      for (int c = 0; c < n; c++) begin
         int waited = 0;
         bit ok = 0;
         if (gaps && $urandom_range(0, 3) == 0) begin
            bus.in_valid = 1'b0;
            repeat ($urandom_range(1, 3)) @(posedge ap_clk);
            #1;
         end
         bus.in_valid = 1'b1;
         bus.in_data  = x[c];
         while (!ok) begin
            @(negedge ap_clk);
            ok = bus.in_ready;
            @(posedge ap_clk);
            #1;
            if (!ok) begin
               waited++;
               if (waited > 1000) begin
                  total++;
                  bad++;
                  $display("FAIL in_accept_timeout: got no accept expected accept of channel %0d", c);
                  bus.in_valid = 1'b0;
                  return;
               end
            end
         end
         if (c == 0) gap0 = waited;
         if (chk_lat) check("latency_valid", bus.out_valid, (c >= HALF) ? 1 : 0);
      end
      bus.in_valid = 1'b0;
   endtask

   task automatic drain();
      int n = 0;
      while (exp_q.size() != 0 && n < 500) begin
         @(posedge ap_clk);
         #1;
         n++;
      end
      check("drain_empty", exp_q.size(), 0);
      repeat (2) begin
         @(posedge ap_clk);
         #1;
      end
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog");
   end

   initial begin : stim
      pix_t ones, ramp, neg, rnd;
      int   g;
      for (int c = 0; c < CH; c++) begin
         ones[c] = 16'sd1;
         ramp[c] = DW'(c);
         neg[c]  = 16'sh8000;
      end
      ap_rst       = 1'b1;
      bus.in_valid = 1'b0;
      bus.in_data  = '0;
      repeat (3) @(posedge ap_clk);
      #1;
      check("rst_out_valid", bus.out_valid, 0);
      check("rst_out_last", bus.out_last, 0);
      check("rst_out_data", bus.out_data, 0);
      ap_rst = 1'b0;
      check("rst_in_ready", bus.in_ready, 1);

      // All ones: 3,4,5,5,5,5,4,3 with output starting after the third accept.
      model(ones);
      send_pixel(ones, CH, 0, 1, g);
      drain();

      model(ramp);
      send_pixel(ramp, CH, 0, 0, g);
      drain();

      model(neg);
      send_pixel(neg, CH, 0, 0, g);
      drain();

      // Ramp under random backpressure.
      rdy_mode = 1;
      model(ramp);
      send_pixel(ramp, CH, 0, 0, g);
      drain();
      rdy_mode = 0;
      repeat (2) @(posedge ap_clk);
      #1;

      // Back-to-back pixels: flush gap must be exactly HALF cycles.
      model(ramp);
      model(ones);
      send_pixel(ramp, CH, 0, 0, g);
      send_pixel(ones, CH, 0, 0, g);
      check("pixel_gap", g, HALF);
      drain();

      // Reset mid-pixel discards the partial pixel.
      ignore_out = 1;
      send_pixel(ones, 4, 0, 0, g);
      ap_rst = 1'b1;
      @(posedge ap_clk);
      #1;
      ap_rst = 1'b0;
      check("post_reset_valid", bus.out_valid, 0);
      ignore_out = 0;
      model(ones);
      send_pixel(ones, CH, 0, 1, g);
      drain();

      // Random pixels with input gaps and random backpressure.
      rdy_mode = 1;
      repeat (4) begin
         for (int c = 0; c < CH; c++) rnd[c] = DW'($urandom);
         model(rnd);
         send_pixel(rnd, CH, 1, 0, g);
      end
      drain();
      rdy_mode = 0;

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
